// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> BUSYn -> RESP -> IDLE per access.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  input  logic [DW-1:0] mem_RD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_we;
  logic          r_last_gnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_any;
  logic          w_win;

  // w_win: 1 selects port 1, 0 selects port 0
  always_comb begin
    w_any = req0 | req1;
`ifdef ARB_ROUND_ROBIN_EN
    w_win = (req0 && req1) ? ~r_last_gnt : ~req0;
`else
    w_win = ~req0;
`endif
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = w_win ? BUSY1 : BUSY0;
      BUSY0,
      BUSY1:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_last_gnt <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_we       <= w_win ? we1 : we0;
        r_addr     <= w_win ? addr1 : addr0;
        r_wdata    <= w_win ? wdata1 : wdata0;
        r_last_gnt <= w_win;
      end
      if (r_state == BUSY0 && !r_we) r_rdata0 <= mem_RD;
      if (r_state == BUSY1 && !r_we) r_rdata1 <= mem_RD;
    end
  end

  // r_last_gnt doubles as the port identifier during RESP
  assign gnt0    = (r_state == BUSY0);
  assign gnt1    = (r_state == BUSY1);
  assign mem_we  = (r_state == BUSY0 || r_state == BUSY1) && r_we;
  assign mem_A   = r_addr;
  assign mem_WD  = r_wdata;
  assign rvalid0 = (r_state == RESP) && !r_we && !r_last_gnt;
  assign rvalid1 = (r_state == RESP) && !r_we &&  r_last_gnt;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule
